// File: rtl/plic_pkg.sv
// Shared constants, gateway state type and helpers for the PLIC.
// Address offsets are byte offsets inside the 4 KiB APB window.
package plic_pkg;

  localparam logic [11:0] PRIO_BASE  = 12'h000;
  localparam logic [11:0] IP_ADDR    = 12'h080;
  localparam logic [11:0] TRIG_ADDR  = 12'h084;
  localparam logic [11:0] CTX_BASE   = 12'h100;
  localparam logic [11:0] CTX_STRIDE = 12'h010;
  localparam logic [11:0] IE_OFF     = 12'h000;
  localparam logic [11:0] THOLD_OFF  = 12'h004;
  localparam logic [11:0] CLAIM_OFF  = 12'h008;

  typedef enum logic [1:0] {
    GW_IDLE   = 2'd0,
    GW_PEND   = 2'd1,
    GW_FLIGHT = 2'd2
  } plic_gw_state_e;

  function automatic int plic_id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: IDLE/PEND/FLIGHT FSM plus edge latch.
// Edge trigger and the EP latch exist only with PLIC_EDGE_TRIG_EN.
module plic_gateway
  import plic_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic trig,
  input  logic claim,
  input  logic complete,
  input  logic ep_clr,
  output logic ip
);

  plic_gw_state_e state, state_n;
  logic evt;
  logic ep;
  logic ep_n;

`ifdef PLIC_EDGE_TRIG_EN
  logic irq_q;
  logic rise;

  // previous line value for the 0->1 detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq;
  end

  assign rise = irq & ~irq_q;
  assign evt  = trig ? rise : irq;

  // one extra edge held while the source is busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ep <= 1'b0;
    else     ep <= ep_n;
  end
`else
  logic unused_cfg;
  assign unused_cfg = trig ^ ep_clr;
  assign evt = irq;
  assign ep  = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= GW_IDLE;
    else     state <= state_n;
  end

  // next state and edge latch update
  always_comb begin
    state_n = state;
    ep_n    = ep;
    unique case (state)
      GW_IDLE:   if (evt) state_n = GW_PEND;
      GW_PEND:   if (claim) state_n = GW_FLIGHT;
      GW_FLIGHT: if (complete) state_n = (ep || evt) ? GW_PEND : GW_IDLE;
      default:   state_n = GW_IDLE;
    endcase
`ifdef PLIC_EDGE_TRIG_EN
    if (state == GW_FLIGHT && complete) ep_n = 1'b0;
    else if (trig && rise && state != GW_IDLE) ep_n = 1'b1;
    if (ep_clr) ep_n = 1'b0;
`endif
  end

  assign ip = (state == GW_PEND);

endmodule

// File: rtl/apb4_plic_mc.sv
// Multi-context PLIC with an APB4 register port.
// Define PLIC_EDGE_TRIG_EN to add the TRIG register and edge gateways.
module apb4_plic_mc
  import plic_pkg::*;
#(
  parameter int IRQ_NUM    = 32,
  parameter int PRIO_WIDTH = 3,
  parameter int CTX_NUM    = 2
) (
  input  logic                 pclk,
  input  logic                 prst,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [11:0]          paddr,
  input  logic [31:0]          pwdata,
  output logic [31:0]          prdata,
  output logic                 pready,
  output logic                 pslverr,
  input  logic [IRQ_NUM-1:0]   irq_i,
  output logic [CTX_NUM-1:0]   ext_irq_o
);

  localparam int IDW = plic_id_width(IRQ_NUM);

  logic [PRIO_WIDTH-1:0] prio [IRQ_NUM];
  logic [IRQ_NUM-1:0]    ie   [CTX_NUM];
  logic [PRIO_WIDTH-1:0] thold [CTX_NUM];
  logic [IDW-1:0]        win_id [CTX_NUM];
  logic [PRIO_WIDTH-1:0] win_prio [CTX_NUM];

  logic [IRQ_NUM-1:0] trig, ip, claim, cmpl, ep_clr;
  logic [CTX_NUM-1:0] ctx_sel;
  logic [IDW-1:0]     claim_id;

  logic acc, wr_acc, rd_acc;
  logic prio_hit, prio_ok, ip_hit, trig_hit;
  logic ie_hit, th_hit, cl_hit, ctx_any;
  logic [4:0] pidx;

  assign acc    = psel & penable;
  assign wr_acc = acc & pwrite;
  assign rd_acc = acc & ~pwrite;
  assign pready = 1'b1;

  assign pidx     = paddr[6:2];
  assign prio_hit = paddr[11:7] == PRIO_BASE[11:7];
  assign prio_ok  = prio_hit & ({27'd0, pidx} < 32'(IRQ_NUM));
  assign ip_hit   = paddr[11:2] == IP_ADDR[11:2];
  assign trig_hit = paddr[11:2] == TRIG_ADDR[11:2];

  // context window decode, one select per implemented context
  always_comb begin
    logic [11:0] base;
    base    = '0;
    ctx_sel = '0;
    for (int c = 0; c < CTX_NUM; c++) begin
      base       = CTX_BASE + CTX_STRIDE * 12'(c);
      ctx_sel[c] = paddr[11:4] == base[11:4];
    end
  end

  assign ctx_any = |ctx_sel;
  assign ie_hit  = ctx_any & (paddr[3:2] == IE_OFF[3:2]);
  assign th_hit  = ctx_any & (paddr[3:2] == THOLD_OFF[3:2]);
  assign cl_hit  = ctx_any & (paddr[3:2] == CLAIM_OFF[3:2]);

  assign pslverr = acc &
    ~(prio_ok | ip_hit | trig_hit | ie_hit | th_hit | cl_hit);

  // register file writes
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      for (int i = 0; i < IRQ_NUM; i++) prio[i] <= '0;
      for (int c = 0; c < CTX_NUM; c++) begin
        ie[c]    <= '0;
        thold[c] <= '0;
      end
    end else if (wr_acc) begin
      for (int i = 1; i < IRQ_NUM; i++)
        if (prio_hit && pidx == 5'(i))
          prio[i] <= pwdata[PRIO_WIDTH-1:0];
      for (int c = 0; c < CTX_NUM; c++) begin
        if (ie_hit && ctx_sel[c])
          ie[c] <= {pwdata[IRQ_NUM-1:1], 1'b0};
        if (th_hit && ctx_sel[c])
          thold[c] <= pwdata[PRIO_WIDTH-1:0];
      end
    end
  end

`ifdef PLIC_EDGE_TRIG_EN
  logic [IRQ_NUM-1:0] trig_new;
  assign trig_new = {pwdata[IRQ_NUM-1:1], 1'b0};
  assign ep_clr   = (wr_acc & trig_hit) ? (trig ^ trig_new) : '0;

  // trigger mode register, 1 = edge
  always_ff @(posedge pclk or posedge prst) begin
    if (prst)                  trig <= '0;
    else if (wr_acc && trig_hit) trig <= trig_new;
  end
`else
  assign trig   = '0;
  assign ep_clr = '0;
`endif

  // per-context max scan; strict > keeps the lowest ID on ties
  always_comb begin
    ext_irq_o = '0;
    for (int c = 0; c < CTX_NUM; c++) begin
      win_id[c]   = '0;
      win_prio[c] = '0;
      for (int i = 1; i < IRQ_NUM; i++)
        if (ip[i] && ie[c][i] && prio[i] > win_prio[c]) begin
          win_prio[c] = prio[i];
          win_id[c]   = IDW'(i);
        end
      ext_irq_o[c] = win_prio[c] > thold[c];
    end
  end

  // claim/complete strobes towards the gateways
  always_comb begin
    claim_id = '0;
    for (int c = 0; c < CTX_NUM; c++)
      if (ctx_sel[c]) claim_id = win_id[c];
    claim = '0;
    cmpl  = '0;
    for (int i = 1; i < IRQ_NUM; i++) begin
      claim[i] = rd_acc & cl_hit & (claim_id == IDW'(i));
      cmpl[i]  = wr_acc & cl_hit & (pwdata[4:0] == 5'(i));
    end
  end

  // read data mux, zero outside read access phases
  always_comb begin
    prdata = '0;
    if (rd_acc) begin
      for (int i = 1; i < IRQ_NUM; i++)
        if (prio_hit && pidx == 5'(i))
          prdata[PRIO_WIDTH-1:0] = prio[i];
      if (ip_hit)   prdata[IRQ_NUM-1:0] = ip;
      if (trig_hit) prdata[IRQ_NUM-1:0] = trig;
      for (int c = 0; c < CTX_NUM; c++)
        if (ctx_sel[c]) begin
          if (ie_hit) prdata[IRQ_NUM-1:0]    = ie[c];
          if (th_hit) prdata[PRIO_WIDTH-1:0] = thold[c];
          if (cl_hit) prdata[IDW-1:0]        = win_id[c];
        end
    end
  end

  assign ip[0] = 1'b0;

  for (genvar i = 1; i < IRQ_NUM; i++) begin : g_gw
    plic_gateway u_gw (
      .clk      (pclk),
      .rst      (prst),
      .irq      (irq_i[i]),
      .trig     (trig[i]),
      .claim    (claim[i]),
      .complete (cmpl[i]),
      .ep_clr   (ep_clr[i]),
      .ip       (ip[i])
    );
  end

  logic unused_top;
  assign unused_top = ^{paddr[1:0], irq_i[0], trig[0],
                        claim[0], cmpl[0], ep_clr[0]};

endmodule

// File: tb/tb_apb4_plic_mc.sv
// Self-checking bench for apb4_plic_mc with a behavioural model.
// Edge-mode checks are built when PLIC_EDGE_TRIG_EN is defined.
module tb_apb4_plic_mc;

  localparam int N  = 32;
  localparam int PW = 3;
  localparam int NC = 2;
  localparam int S_IDLE = 0, S_PEND = 1, S_FLIGHT = 2;
`ifdef PLIC_EDGE_TRIG_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic pclk = 1'b0;
  logic prst, psel, penable, pwrite, pready, pslverr;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic [N-1:0] irq_i;
  logic [NC-1:0] ext_irq_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 pclk = ~pclk;

  apb4_plic_mc #(.IRQ_NUM(N), .PRIO_WIDTH(PW), .CTX_NUM(NC)) dut (
    .pclk(pclk), .prst(prst), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .irq_i(irq_i),
    .ext_irq_o(ext_irq_o)
  );

  // reference model state
  int m_prio [N];
  int m_thold [NC];
  logic [N-1:0] m_ie [NC];
  logic [N-1:0] m_trig;
  int m_st [N];
  bit m_ep [N];
  bit m_prev [N];

  function automatic int win(int c);
    int best = 0;
    for (int i = 1; i < N; i++)
      if (m_st[i] == S_PEND && m_ie[c][i] && m_prio[i] > m_prio[best])
        best = i;
    return best;
  endfunction

  function automatic logic [NC-1:0] m_ext();
    logic [NC-1:0] r = '0;
    for (int c = 0; c < NC; c++) r[c] = m_prio[win(c)] > m_thold[c];
    return r;
  endfunction

  function automatic bit in_ctx(logic [11:0] a);
    return a >= 12'h100 && a < 12'h100 + 16 * NC;
  endfunction

  function automatic logic [31:0] m_rdata(logic [11:0] a0);
    logic [11:0] a = {a0[11:2], 2'b00};
    logic [31:0] r = '0;
    int c;
    if (a < 12'h080) r = m_prio[a >> 2];
    else if (a == 12'h080)
      for (int i = 1; i < N; i++) r[i] = (m_st[i] == S_PEND);
    else if (a == 12'h084) r = m_trig;
    else if (in_ctx(a)) begin
      c = (a - 12'h100) >> 4;
      case (a[3:2])
        2'd0: r = m_ie[c];
        2'd1: r = m_thold[c];
        2'd2: r = win(c);
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  function automatic bit m_err(logic [11:0] a0);
    logic [11:0] a = {a0[11:2], 2'b00};
    if (a < 12'h080 || a == 12'h080 || a == 12'h084) return 1'b0;
    if (in_ctx(a) && a[3:2] != 2'd3) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_prio[i] = 0; m_st[i] = S_IDLE; m_ep[i] = 0; m_prev[i] = 0;
    end
    for (int c = 0; c < NC; c++) begin m_ie[c] = '0; m_thold[c] = 0; end
    m_trig = '0;
  endtask

  // advance one clock, updating the model from the bus and irq lines
  task automatic step();
    bit acc, rise, edg, ev;
    logic [11:0] a;
    int cl, cm, c;
    int n_st [N];
    bit n_ep [N];
    acc = psel && penable;
    a = {paddr[11:2], 2'b00};
    cl = 0; cm = 0; c = 0;
    if (in_ctx(a)) c = (a - 12'h100) >> 4;
    if (acc && in_ctx(a) && a[3:2] == 2'd2) begin
      if (pwrite) cm = int'(pwdata[4:0]);
      else cl = win(c);
    end
    for (int i = 0; i < N; i++) begin n_st[i] = m_st[i]; n_ep[i] = m_ep[i]; end
    for (int i = 1; i < N; i++) begin
      rise = irq_i[i] && !m_prev[i];
      edg = EDGE && m_trig[i];
      ev = edg ? rise : irq_i[i];
      if (m_st[i] == S_IDLE && ev) n_st[i] = S_PEND;
      if (m_st[i] == S_PEND && cl == i) n_st[i] = S_FLIGHT;
      if (m_st[i] == S_FLIGHT && cm == i)
        n_st[i] = (m_ep[i] || ev) ? S_PEND : S_IDLE;
      if (m_st[i] == S_FLIGHT && cm == i) n_ep[i] = 0;
      else if (edg && rise && m_st[i] != S_IDLE) n_ep[i] = 1;
      if (EDGE && acc && pwrite && a == 12'h084 && i > 0 &&
          pwdata[i] != m_trig[i]) n_ep[i] = 0;
    end
    @(posedge pclk);
    for (int i = 0; i < N; i++) begin
      m_st[i] = n_st[i]; m_ep[i] = n_ep[i]; m_prev[i] = irq_i[i];
    end
    if (acc && pwrite) begin
      if (a < 12'h080 && a != 12'h000) m_prio[a >> 2] = int'(pwdata[PW-1:0]);
      if (a == 12'h084 && EDGE) m_trig = {pwdata[N-1:1], 1'b0};
      if (in_ctx(a) && a[3:2] == 2'd0) m_ie[c] = {pwdata[N-1:1], 1'b0};
      if (in_ctx(a) && a[3:2] == 2'd1) m_thold[c] = int'(pwdata[PW-1:0]);
    end
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    step();
    penable = 1;
    step();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d,
                    output logic e, output logic [31:0] xd, output logic xe);
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    step();
    penable = 1;
    #1;
    d = prdata; e = pslverr; xd = m_rdata(a); xe = m_err(a);
    step();
    psel = 0; penable = 0;
  endtask

  task automatic do_reset();
    prst = 1; psel = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; irq_i = '0;
    model_reset();
    repeat (2) @(posedge pclk);
    #1 prst = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d, xd; logic e, xe;
    do_reset();
    tests_run++;
    if (ext_irq_o !== 2'b00 || pready !== 1'b1 || pslverr !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out: ext=%b rdy=%b err=%b want 00 1 0",
               ext_irq_o, pready, pslverr);
    end
    tests_run++;
    if (prdata !== 32'd0) begin
      tests_failed++; $display("FAIL reset_prdata: got %h want 0", prdata);
    end
    foreach (d[k]) ;
    rd(12'h004, d, e, xd, xe);
    tests_run++;
    if (d !== 32'd0) begin
      tests_failed++; $display("FAIL reset_prio1: got %h want 0", d);
    end
    rd(12'h110, d, e, xd, xe);
    tests_run++;
    if (d !== 32'd0) begin
      tests_failed++; $display("FAIL reset_ie1: got %h want 0", d);
    end
    rd(12'h080, d, e, xd, xe);
    tests_run++;
    if (d !== 32'd0) begin
      tests_failed++; $display("FAIL reset_ip: got %h want 0", d);
    end
  endtask

  task automatic test_level();
    logic [31:0] d, xd; logic e, xe;
    do_reset();
    wr(12'h00C, 2); wr(12'h100, 32'h8); wr(12'h104, 1);
    irq_i[3] = 1;
    tests_run++;
    if (ext_irq_o[0] !== 1'b0) begin
      tests_failed++; $display("FAIL level_pre: got %b want 0", ext_irq_o[0]);
    end
    step();
    tests_run++;
    if (ext_irq_o[0] !== 1'b1) begin
      tests_failed++; $display("FAIL level_ext: got %b want 1", ext_irq_o[0]);
    end
    rd(12'h108, d, e, xd, xe);
    tests_run++;
    if (d !== 32'd3) begin
      tests_failed++; $display("FAIL level_claim: got %0d want 3", d);
    end
    rd(12'h080, d, e, xd, xe);
    tests_run++;
    if (d[3] !== 1'b0 || ext_irq_o[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL level_ip_clr: ip3=%b ext=%b want 0 0", d[3], ext_irq_o[0]);
    end
    wr(12'h108, 3);
    rd(12'h080, d, e, xd, xe);
    tests_run++;
    if (d !== 32'h8) begin
      tests_failed++; $display("FAIL level_repend: got %h want 8", d);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d, xd; logic e, xe;
    int want [4] = '{5, 7, 2, 0};
    do_reset();
    wr(12'h014, 4); wr(12'h01C, 4); wr(12'h008, 1);
    wr(12'h100, 32'hA4);
    irq_i = 32'hA4;
    step();
    for (int k = 0; k < 4; k++) begin
      rd(12'h108, d, e, xd, xe);
      tests_run++;
      if (d !== 32'(want[k])) begin
        tests_failed++;
        $display("FAIL prio_claim%0d: got %0d want %0d", k, d, want[k]);
      end
    end
  endtask

  task automatic test_threshold();
    logic [31:0] d, xd; logic e, xe;
    do_reset();
    wr(12'h010, 2); wr(12'h110, 32'h10); wr(12'h114, 2);
    irq_i[4] = 1;
    step();
    tests_run++;
    if (ext_irq_o[1] !== 1'b0) begin
      tests_failed++; $display("FAIL thold_mask: got %b want 0", ext_irq_o[1]);
    end
    rd(12'h118, d, e, xd, xe);
    tests_run++;
    if (d !== 32'd4) begin
      tests_failed++; $display("FAIL thold_claim: got %0d want 4", d);
    end
    wr(12'h118, 4);
    wr(12'h114, 1);
    tests_run++;
    if (ext_irq_o[1] !== 1'b1) begin
      tests_failed++; $display("FAIL thold_pass: got %b want 1", ext_irq_o[1]);
    end
  endtask

  task automatic pulse1();
    irq_i[1] = 1; step(); irq_i[1] = 0; step();
  endtask

  task automatic test_edge();
    logic [31:0] d, xd; logic e, xe;
    do_reset();
`ifdef PLIC_EDGE_TRIG_EN
    wr(12'h004, 1); wr(12'h100, 32'h2); wr(12'h084, 32'h2);
    pulse1();
    rd(12'h108, d, e, xd, xe);
    tests_run++;
    if (d !== 32'd1) begin
      tests_failed++; $display("FAIL edge_claim1: got %0d want 1", d);
    end
    pulse1();
    pulse1();
    wr(12'h108, 1);
    rd(12'h080, d, e, xd, xe);
    tests_run++;
    if (d !== 32'h2) begin
      tests_failed++; $display("FAIL edge_ep_repend: got %h want 2", d);
    end
    rd(12'h108, d, e, xd, xe);
    wr(12'h108, 1);
    rd(12'h080, d, e, xd, xe);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++; $display("FAIL edge_drained: got %h want 0", d);
    end
`else
    wr(12'h084, 32'hFFFF_FFFF);
    rd(12'h084, d, e, xd, xe);
    tests_run++;
    if (d !== 32'd0 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL trig_absent: data=%h err=%b want 0 0", d, e);
    end
`endif
  endtask

  task automatic test_multi_ctx();
    logic [31:0] d, xd; logic e, xe;
    do_reset();
    wr(12'h010, 3); wr(12'h100, 32'h10); wr(12'h110, 32'h10);
    irq_i[4] = 1;
    step();
    tests_run++;
    if (ext_irq_o !== 2'b11) begin
      tests_failed++; $display("FAIL mc_both: got %b want 11", ext_irq_o);
    end
    rd(12'h118, d, e, xd, xe);
    tests_run++;
    if (d !== 32'd4 || ext_irq_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL mc_claim: id=%0d ext=%b want 4 00", d, ext_irq_o);
    end
    wr(12'h108, 9);
    tests_run++;
    if (ext_irq_o !== 2'b00) begin
      tests_failed++; $display("FAIL mc_bad_cmpl: got %b want 00", ext_irq_o);
    end
    wr(12'h108, 4);
    tests_run++;
    if (ext_irq_o !== 2'b11) begin
      tests_failed++; $display("FAIL mc_cmpl: got %b want 11", ext_irq_o);
    end
  endtask

  task automatic test_errors_reset();
    logic [31:0] d, xd; logic e, xe;
    do_reset();
    rd(12'h0F0, d, e, xd, xe);
    tests_run++;
    if (e !== 1'b1 || d !== 32'd0) begin
      tests_failed++; $display("FAIL err_0f0: err=%b data=%h want 1 0", e, d);
    end
    rd(12'h120, d, e, xd, xe);
    tests_run++;
    if (e !== 1'b1 || d !== 32'd0) begin
      tests_failed++; $display("FAIL err_ctx2: err=%b data=%h want 1 0", e, d);
    end
    rd(12'h10C, d, e, xd, xe);
    tests_run++;
    if (e !== 1'b1) begin
      tests_failed++; $display("FAIL err_off_c: err=%b want 1", e);
    end
    wr(12'h004, 6);
    psel = 1; penable = 0; pwrite = 1; paddr = 12'h004; pwdata = 32'd3;
    step();
    penable = 1;
    #2 prst = 1;
    #1;
    model_reset();
    psel = 0; penable = 0; pwrite = 0;
    @(posedge pclk);
    #1 prst = 0;
    rd(12'h004, d, e, xd, xe);
    tests_run++;
    if (d !== 32'd0) begin
      tests_failed++; $display("FAIL rst_mid_write: got %h want 0", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, xd; logic e, xe;
    int op, c, id;
    do_reset();
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 7);
      c = $urandom_range(0, NC - 1);
      case (op)
        0: begin irq_i = $urandom() & $urandom(); step(); end
        1: wr(12'($urandom_range(0, 31) * 4), $urandom());
        2: wr(12'h100 + 12'(16 * c), $urandom());
        3: wr(12'h104 + 12'(16 * c), $urandom());
        4, 7: begin
          rd(op == 4 ? 12'h108 + 12'(16 * c) : 12'h080, d, e, xd, xe);
          tests_run++;
          if (d !== xd || e !== xe) begin
            tests_failed++;
            $display("FAIL rand_read%0d: data=%h err=%b want %h %b",
                     it, d, e, xd, xe);
          end
        end
        5: begin
          id = $urandom_range(0, 31);
          for (int i = 1; i < N; i++)
            if (m_st[i] == S_FLIGHT && $urandom_range(0, 1) == 1) id = i;
          wr(12'h108 + 12'(16 * c), 32'(id));
        end
        default: wr(12'h084, $urandom());
      endcase
      tests_run++;
      if (ext_irq_o !== m_ext()) begin
        tests_failed++;
        $display("FAIL rand_ext%0d: got %b want %b", it, ext_irq_o, m_ext());
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    prst = 1; psel = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; irq_i = '0;
    test_reset();
    test_level();
    test_priority();
    test_threshold();
    test_edge();
    test_multi_ctx();
    test_errors_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
